crypto_sequencer: RTL and testbench
===================================

# crypto_sequencer

Hardware controller that sequences one LFSR stream-cipher pass over the shared data memory. It replaces the instruction-driven program for the encrypt and decrypt jobs. The block reads the job configuration from DM[41..43]. In encrypt mode it produces the 64-byte padded ciphertext in DM[64..127]; in decrypt mode it recovers the 41-byte plaintext into DM[0..40]. It sits beside the data-memory port of the top level and raises `done` when the pass is complete.

## Interface
Parameters:
- `MSG_LEN`, 41: plaintext length in bytes.
- `FRAME_LEN`, 64: padded ciphertext length in bytes.
- `CFG_BASE`, 41: address of the pre_length byte; taps are at +1, LFSR init at +2.
- `CT_BASE`, 64: ciphertext base address.
- `PAD_CHAR`, 8'h20: padding byte (ASCII space).

Ports:
- `CLK`, in, 1: the single clock; rising-edge.
- `start`, in, 1: synchronous, active-high reset. The job begins on the first edge after release.
- `mode`, in, 1: 0 = encrypt, 1 = decrypt. Sampled on the first edge after `start` falls; ignored after that.
- `mem_addr`, out, 8: data-memory address.
- `mem_wr_en`, out, 1: write strobe; memory writes `mem_wdata` at the rising edge.
- `mem_wdata`, out, 8: write data.
- `mem_rdata`, in, 8: read data for the address presented one cycle earlier (1-cycle registered read).
- `busy`, out, 1: high from the first edge after release until `done` rises.
- `done`, out, 1: job complete; holds high until `start` is asserted.

## Operation
- The LFSR step is `lfsr_next = {lfsr[6:0], ^(lfsr & taps)}`, 8-bit, with lfsr_0 = init.
  - Key byte i is lfsr_i.
  - init = 0 is legal and gives an all-zero key stream.
- pre_eff = min(DM[41], FRAME_LEN-MSG_LEN), i.e. min(DM[41], 23).
- State machine states and transitions:
  - IDLE: held while `start` = 1.
  - LOAD: issues reads of 41, 42, 43 on cycles 0-2. Captures pre, taps, init on cycles 1-3. Exits after cycle 3.
  - SKIP (decrypt only): steps the LFSR pre_eff times, one step per cycle, writing nothing.
  - RD: presents the read address; no write.
  - WR: writes one output byte and steps the LFSR.
  - PAD (encrypt only): writes one padding byte in a single cycle and steps the LFSR.
  - DONE: terminal; no memory activity.
- Encrypt mode, for i = 0..63:
  - If pre_eff ≤ i < pre_eff+41: RD addr i-pre_eff, then WR addr 64+i with data mem_rdata ^ lfsr_i.
  - Otherwise: PAD writes addr 64+i with data 8'h20 ^ lfsr_i.
- Decrypt mode:
  - After SKIP, for j = 0..40: RD addr 64+pre_eff+j, then WR addr j with data mem_rdata ^ lfsr_(pre_eff+j).
  - Trailing ciphertext bytes are not read.
- `mem_wr_en` is high only in WR and PAD. `mem_addr` and `mem_wdata` hold their last values elsewhere.
- The block never writes DM[41..63] and never writes above 127.

## Timing
- Reset values, on every edge with `start` = 1:
  - state IDLE, lfsr 0.
  - `mem_addr` 0, `mem_wr_en` 0, `mem_wdata` 0.
  - `busy` 0, `done` 0.
- Edge 1 is the first rising edge with `start` = 0.
- Encrypt takes 4 + 23 + 2·41 = 109 cycles. `done` is high after edge 109 regardless of pre_eff.
- Decrypt takes 4 + pre_eff + 82 cycles.
- Read/write pairs:
  - The address is presented in RD cycle k; data is valid and written in WR cycle k+1.
  - There are no back-to-back reads without an intervening write.
- Reset mid-job: asserting `start` on any edge aborts the job.
  - `mem_wr_en` is 0 from that edge onward.
  - Partial memory writes remain.
  - Release restarts from LOAD with fresh config.
- `start` asserted while in DONE: `done` falls on that edge.
- DM[41] > 23: clamped to 23, with no error flag.

## Test plan
- Encrypt, pre=9, taps=8'hd4, init=8'h40, str "Mr. Watson, come here. I want to see you.":
  - DM[64] = 8'h60 and DM[65] = 8'hA1 (lfsr_1 = 8'h81).
  - DM[73] = 'M' ^ lfsr_9.
  - All 64 bytes match the reference model; `done` rises after edge 109.
- Encrypt with init=0, pre=11:
  - DM[64..74] and DM[116..127] = 8'h20.
  - DM[75..115] = plaintext unchanged.
- Decrypt round trip, taps=8'hb4, init=8'h35, pre=9, ciphertext precomputed by the model:
  - DM[0..40] = "Knowledge comes, but wisdom lingers.     ".
  - `done` rises after edge 4+9+82 = 95.
  - DM[64..127] are unmodified.
- Reset mid-job: assert `start` at edge 50 for 2 cycles.
  - `mem_wr_en` = 0 and `done` = 0 during reset.
  - The rerun produces a correct full frame and `done` at edge 109 after release.
- Clamp: DM[41] = 8'd40, encrypt.
  - Behaves exactly as pre=23: DM[87..127] hold message ^ key.
  - DM[41..43] are unchanged.
- Back-to-back jobs (encrypt, decrypt, encrypt, decrypt with taps e1/b2/fa) toggling `start` between jobs:
  - Each result matches the model.
  - `busy` and `done` are never high simultaneously.

Source files
------------

// File: rtl/crypto_sequencer_if.sv
// Data-memory port plus job control/status of the LFSR cipher sequencer.
// master = sequencer side, slave = memory / job owner side.
interface crypto_sequencer_if;
  logic       mode;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;

  modport master (
    input  mode, mem_rdata,
    output mem_addr, mem_wr_en, mem_wdata, busy, done
  );

  modport slave (
    output mode, mem_rdata,
    input  mem_addr, mem_wr_en, mem_wdata, busy, done
  );
endinterface

// File: rtl/crypto_sequencer.sv
// Sequences one LFSR stream-cipher pass (encrypt: pad+XOR into the frame; decrypt: XOR back to plaintext).
// Latency: encrypt 109 edges, decrypt 4+pre_eff+82 edges; no backpressure, memory answers every read next cycle.
module crypto_sequencer #(
  parameter int         MSG_LEN   = 41,
  parameter int         FRAME_LEN = 64,
  parameter int         CFG_BASE  = 41,
  parameter int         CT_BASE   = 64,
  parameter logic [7:0] PAD_CHAR  = 8'h20
) (
  input logic                CLK,
  input logic                start,
  crypto_sequencer_if.master bus
);

  localparam logic [7:0] PRE_MAX = 8'(FRAME_LEN - MSG_LEN);
  localparam logic [7:0] CFG_A   = 8'(CFG_BASE);
  localparam logic [7:0] CT_A    = 8'(CT_BASE);
  localparam logic [7:0] MSG_L   = 8'(MSG_LEN);
  localparam logic [7:0] LAST_PT = 8'(MSG_LEN - 1);
  localparam logic [7:0] LAST_CT = 8'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SKIP, S_RD, S_WR, S_PAD, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pre_q, pre_d;
  logic [7:0] taps_q, taps_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       mode_q, mode_d;
  logic       wr_en;
  logic [7:0] lfsr_step;
  logic [7:0] cnt_inc;
  logic       next_in_msg;

  assign lfsr_step   = {lfsr_q[6:0], ^(lfsr_q & taps_q)};
  assign cnt_inc     = cnt_q + 8'd1;
  // Frame index cnt+1 falls inside the message window [pre_eff, pre_eff+MSG_LEN)
  assign next_in_msg = (cnt_inc >= pre_q) && (cnt_inc < pre_q + MSG_L);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    taps_d  = taps_q;
    lfsr_d  = lfsr_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Cycle 0 of the load is the cycle before edge 1, so the first read is already presented here
        if (!start) begin
          addr_d  = CFG_A;
          mode_d  = bus.mode;
          cnt_d   = 8'd1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        case (cnt_q)
          8'd1: begin
            addr_d = CFG_A + 8'd1;
            pre_d  = (bus.mem_rdata > PRE_MAX) ? PRE_MAX : bus.mem_rdata;
            cnt_d  = 8'd2;
          end
          8'd2: begin
            addr_d = CFG_A + 8'd2;
            taps_d = bus.mem_rdata;
            cnt_d  = 8'd3;
          end
          default: begin
            lfsr_d = bus.mem_rdata;
            cnt_d  = 8'd0;
            if (mode_q) state_d = (pre_q == 8'd0) ? S_RD : S_SKIP;
            else        state_d = (pre_q == 8'd0) ? S_RD : S_PAD;
          end
        endcase
      end
      S_SKIP: begin
        lfsr_d = lfsr_step;
        if (cnt_inc == pre_q) begin
          cnt_d   = 8'd0;
          state_d = S_RD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RD: begin
        addr_d  = mode_q ? (CT_A + pre_q + cnt_q) : (cnt_q - pre_q);
        state_d = S_WR;
      end
      S_WR, S_PAD: begin
        wr_en   = 1'b1;
        addr_d  = mode_q ? cnt_q : (CT_A + cnt_q);
        wdata_d = ((state_q == S_PAD) ? PAD_CHAR : bus.mem_rdata) ^ lfsr_q;
        lfsr_d  = lfsr_step;
        if (mode_q) begin
          if (cnt_q == LAST_PT) state_d = S_DONE;
          else begin
            cnt_d   = cnt_inc;
            state_d = S_RD;
          end
        end else begin
          if (cnt_q == LAST_CT) state_d = S_DONE;
          else begin
            cnt_d   = cnt_inc;
            state_d = next_in_msg ? S_RD : S_PAD;
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_addr  = addr_d;
  assign bus.mem_wdata = wdata_d;
  assign bus.mem_wr_en = wr_en;
  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done      = (state_q == S_DONE);

  always_ff @(posedge CLK) begin
    if (start) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      pre_q   <= 8'd0;
      taps_q  <= 8'd0;
      lfsr_q  <= 8'd0;
      mode_q  <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      taps_q  <= taps_d;
      lfsr_q  <= lfsr_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_crypto_sequencer.sv
// Bench for crypto_sequencer: 256-byte data memory with 1-cycle registered read,
// frame-level cipher model, per-scenario tasks.
module tb_crypto_sequencer;

  logic clk;
  logic start;
  logic bd_load;

  crypto_sequencer_if bus ();

  crypto_sequencer dut (
    .CLK   (clk),
    .start (start),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] dm     [256];
  logic [7:0] img    [256];
  logic [7:0] msg    [41];
  logic [7:0] ks     [64];
  logic [7:0] exp_ct [64];
  int m_pre;
  int tests, fails;
  int bad_wr, overlap;

  always @(posedge clk) begin
    if (bd_load) dm <= img;
    else if (bus.mem_wr_en === 1'b1) dm[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= dm[bus.mem_addr];
  end

  always @(posedge clk)
    if (bus.mem_wr_en === 1'b1 && ((bus.mem_addr >= 8'd41 && bus.mem_addr <= 8'd63) || bus.mem_addr > 8'd127))
      bad_wr <= bad_wr + 1;

  always @(negedge clk)
    if (bus.busy === 1'b1 && bus.done === 1'b1) overlap <= overlap + 1;

  task automatic set_msg(input string s);
    for (int i = 0; i < 41; i++) msg[i] = (i < s.len()) ? 8'(s[i]) : 8'h20;
  endtask

  task automatic rand_msg();
    for (int i = 0; i < 41; i++) msg[i] = 8'($urandom_range(32, 126));
  endtask

  // Key stream and expected 64-byte frame from the written rules
  task automatic model(input logic [7:0] pre_raw, input logic [7:0] taps, input logic [7:0] init);
    logic [7:0] l;
    logic [7:0] src;
    m_pre = (pre_raw > 8'd23) ? 23 : int'(pre_raw);
    l = init;
    for (int i = 0; i < 64; i++) begin
      ks[i] = l;
      l = {l[6:0], ^(l & taps)};
    end
    for (int i = 0; i < 64; i++) begin
      src = (i >= m_pre && i < m_pre + 41) ? msg[i - m_pre] : 8'h20;
      exp_ct[i] = src ^ ks[i];
    end
  endtask

  task automatic prep(input logic md, input logic [7:0] pre_raw, input logic [7:0] taps, input logic [7:0] init);
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    img[41] = pre_raw;
    img[42] = taps;
    img[43] = init;
    if (!md) for (int i = 0; i < 41; i++) img[i] = msg[i];
    else     for (int i = 0; i < 64; i++) img[64 + i] = exp_ct[i];
    bd_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bd_load = 1'b0;
  endtask

  task automatic run_job(input logic md, input int exp_edges, input string name);
    int  n;
    int  busy_gap;
    bit  seen;
    n = 0; busy_gap = 0; seen = 0;
    bus.mode = md;
    start = 1'b0;
    while (!seen && n < 400) begin
      @(posedge clk);
      n++;
      if (n == 1) begin
        #1 bus.mode = ~md;
      end
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1;
      else if (bus.busy !== 1'b1) busy_gap++;
    end
    tests++;
    if (!seen || n != exp_edges) begin
      fails++;
      $display("FAIL %s done_edge: got %0d required %0d", name, seen ? n : -1, exp_edges);
    end
    tests++;
    if (busy_gap != 0) begin
      fails++;
      $display("FAIL %s busy_while_running: %0d low cycles, required 0", name, busy_gap);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (bus.done !== 1'b1 || bus.mem_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL %s done_hold: done=%b wr_en=%b required 1/0", name, bus.done, bus.mem_wr_en);
    end
    start = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.done !== 1'b0) begin
      fails++;
      $display("FAIL %s done_clear: got %b required 0", name, bus.done);
    end
  endtask

  task automatic check_ct(input string name);
    int bad, first;
    bad = 0; first = -1;
    for (int i = 0; i < 64; i++)
      if (dm[64 + i] !== exp_ct[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s frame: %0d bad bytes, first DM[%0d]=%h required %h",
               name, bad, 64 + first, dm[64 + first], exp_ct[first]);
    end
  endtask

  task automatic check_pt(input string name);
    int bad, first;
    bad = 0; first = -1;
    for (int i = 0; i < 41; i++)
      if (dm[i] !== msg[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s plaintext: %0d bad bytes, first DM[%0d]=%h required %h",
               name, bad, first, dm[first], msg[first]);
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    bd_load = 1'b0;
    bus.mode = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus.mem_addr  !== 8'h00) begin fails++; $display("FAIL reset mem_addr: got %h required 00", bus.mem_addr); end
    tests++; if (bus.mem_wr_en !== 1'b0)  begin fails++; $display("FAIL reset mem_wr_en: got %b required 0", bus.mem_wr_en); end
    tests++; if (bus.mem_wdata !== 8'h00) begin fails++; $display("FAIL reset mem_wdata: got %h required 00", bus.mem_wdata); end
    tests++; if (bus.busy      !== 1'b0)  begin fails++; $display("FAIL reset busy: got %b required 0", bus.busy); end
    tests++; if (bus.done      !== 1'b0)  begin fails++; $display("FAIL reset done: got %b required 0", bus.done); end
  endtask

  task automatic test_encrypt_vector();
    set_msg("Mr. Watson, come here. I want to see you.");
    model(8'd9, 8'hd4, 8'h40);
    prep(1'b0, 8'd9, 8'hd4, 8'h40);
    run_job(1'b0, 109, "enc_vec");
    tests++; if (dm[64] !== 8'h60) begin fails++; $display("FAIL enc_vec DM64: got %h required 60", dm[64]); end
    tests++; if (dm[65] !== 8'hA1) begin fails++; $display("FAIL enc_vec DM65: got %h required a1", dm[65]); end
    tests++;
    if (dm[73] !== (8'h4d ^ ks[9])) begin
      fails++; $display("FAIL enc_vec DM73: got %h required %h", dm[73], 8'h4d ^ ks[9]);
    end
    check_ct("enc_vec");
    tests++;
    if (dm[41] !== 8'd9 || dm[42] !== 8'hd4 || dm[43] !== 8'h40) begin
      fails++; $display("FAIL enc_vec cfg_kept: got %h %h %h required 09 d4 40", dm[41], dm[42], dm[43]);
    end
  endtask

  task automatic test_zero_key();
    int bad;
    rand_msg();
    prep(1'b0, 8'd11, 8'($urandom), 8'h00);
    run_job(1'b0, 109, "zero_key");
    bad = 0;
    for (int i = 64; i <= 74; i++)   if (dm[i] !== 8'h20) bad++;
    for (int i = 116; i <= 127; i++) if (dm[i] !== 8'h20) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL zero_key padding: %0d bad bytes, required 0", bad); end
    bad = 0;
    for (int j = 0; j < 41; j++) if (dm[75 + j] !== msg[j]) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL zero_key message: %0d bad bytes, required 0", bad); end
  endtask

  task automatic test_decrypt_roundtrip();
    set_msg("Knowledge comes, but wisdom lingers.     ");
    model(8'd9, 8'hb4, 8'h35);
    prep(1'b1, 8'd9, 8'hb4, 8'h35);
    run_job(1'b1, 95, "dec_rt");
    check_pt("dec_rt");
    check_ct("dec_rt_ct_kept");
  endtask

  task automatic test_reset_mid_job();
    rand_msg();
    model(8'd5, 8'h8e, 8'h5a);
    prep(1'b0, 8'd5, 8'h8e, 8'h5a);
    bus.mode = 1'b0;
    start = 1'b0;
    repeat (49) @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++;
      if (bus.mem_wr_en !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        fails++;
        $display("FAIL abort_idle%0d: wr_en=%b done=%b busy=%b required 0/0/0", k, bus.mem_wr_en, bus.done, bus.busy);
      end
    end
    run_job(1'b0, 109, "rerun");
    check_ct("rerun");
  endtask

  task automatic test_clamp();
    int bad;
    rand_msg();
    model(8'd40, 8'h9c, 8'hc3);
    prep(1'b0, 8'd40, 8'h9c, 8'hc3);
    run_job(1'b0, 109, "clamp");
    bad = 0;
    for (int j = 0; j < 41; j++) if (dm[87 + j] !== (msg[j] ^ ks[23 + j])) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL clamp message_at_87: %0d bad bytes, required 0", bad); end
    check_ct("clamp");
    tests++;
    if (dm[41] !== 8'd40 || dm[42] !== 8'h9c || dm[43] !== 8'hc3) begin
      fails++; $display("FAIL clamp cfg_kept: got %h %h %h required 28 9c c3", dm[41], dm[42], dm[43]);
    end
  endtask

  task automatic run_checked(input logic md, input logic [7:0] pre, input logic [7:0] taps,
                             input logic [7:0] init, input string name);
    rand_msg();
    model(pre, taps, init);
    prep(md, pre, taps, init);
    run_job(md, md ? (4 + m_pre + 82) : 109, name);
    if (md) check_pt(name);
    else    check_ct(name);
  endtask

  task automatic test_back_to_back();
    logic [7:0] tl [4];
    int ov0;
    tl[0] = 8'he1; tl[1] = 8'hb2; tl[2] = 8'hfa; tl[3] = 8'he1;
    ov0 = overlap;
    for (int k = 0; k < 4; k++)
      run_checked(1'(k % 2), 8'($urandom_range(0, 30)), tl[k], 8'($urandom), "b2b");
    tests++;
    if (overlap != ov0) begin fails++; $display("FAIL b2b busy_done_overlap: got %0d cycles required 0", overlap - ov0); end
  endtask

  task automatic test_random();
    logic [7:0] pl [6];
    pl[0] = 8'd0; pl[1] = 8'd23; pl[2] = 8'd24; pl[3] = 8'd255;
    pl[4] = 8'($urandom_range(1, 22)); pl[5] = 8'd0;
    for (int k = 0; k < 6; k++) begin
      run_checked(1'b1, pl[k], 8'($urandom), 8'($urandom), "rand_dec");
      run_checked(1'b0, pl[k], 8'($urandom), 8'($urandom), "rand_enc");
    end
  endtask

  initial begin
    tests = 0; fails = 0; bad_wr = 0; overlap = 0;
    test_reset();
    test_encrypt_vector();
    test_zero_key();
    test_decrypt_roundtrip();
    test_reset_mid_job();
    test_clamp();
    test_back_to_back();
    test_random();
    tests++;
    if (bad_wr != 0) begin fails++; $display("FAIL write_range: %0d writes to 41..63 or >127, required 0", bad_wr); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
